// File: rtl/weighted_mixer.sv
// -----------------------------------------------------------------------------
// weighted_mixer
//
// Sequential weighted audio mixer. On a sample_tick in IDLE the channel
// samples, gains and enables are captured. One channel per cycle is then
// multiplied by its gain and accumulated. The sum is right-shifted by SHIFT
// and saturated to OUT_W bits, and the result is presented on audio with a
// single-cycle audio_valid pulse. The multiply-accumulate runs one channel at
// a time, so only one multiplier is needed whatever NUM is.
//
// Parameters
//   NUM    number of channels (1..16)
//   N      unsigned sample width
//   G      unsigned gain width
//   SHIFT  right shift applied to the weighted sum (gain 2^SHIFT = unity)
//   OUT_W  output sample width
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low
//   samples      NUM*N packed samples, channel i at [N*(i+1)-1:N*i]
//   gains        NUM*G packed gains, same packing
//   channel_ena  per-channel enable, 0 gives a zero contribution
//   sample_tick  single-cycle request for a new mix
//   overrun_clr  clears the sticky overrun flag
//   audio        mixed, saturated sample; holds between updates
//   audio_valid  single-cycle pulse when audio updates
//   busy         high while a mix is in progress (ACCUM and DONE)
//   overrun      sticky: a sample_tick arrived while busy
//
// Optional feature (macro WEIGHTED_MIXER_CLIP_DETECT_EN)
//   clip         pulses with audio_valid when the mix saturated
//   clip_count   8-bit saturating count of saturated mixes
// -----------------------------------------------------------------------------
module weighted_mixer #(
  parameter int NUM   = 4,
  parameter int N     = 10,
  parameter int G     = 4,
  parameter int SHIFT = 3,
  parameter int OUT_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM*N-1:0]   samples,
  input  logic [NUM*G-1:0]   gains,
  input  logic [NUM-1:0]     channel_ena,
  input  logic               sample_tick,
  input  logic               overrun_clr,
  output logic [OUT_W-1:0]   audio,
  output logic               audio_valid,
  output logic               busy,
  output logic               overrun
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
  ,
  output logic               clip,
  output logic [7:0]         clip_count
`endif
);

  // Accumulator wide enough for NUM full-scale products.
  localparam int ACC_W = N + G + $clog2(NUM);
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  // Comparison width: at least one bit wider than both operands so the
  // saturation test works whether ACC_W is larger or smaller than OUT_W.
  localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [CMP_W-1:0] OUT_MAX  = {{(CMP_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;

  // Captured copy of the inputs for the mix in progress.
  logic [NUM*N-1:0]   samples_q;
  logic [NUM*G-1:0]   gains_q;
  logic [NUM-1:0]     ena_q;

  logic [N-1:0]       cur_sample;
  logic [G-1:0]       cur_gain;
  logic               cur_ena;
  logic [ACC_W-1:0]   term;
  logic [CMP_W-1:0]   shifted;
  logic               sat;
  logic [OUT_W-1:0]   mix_out;

  // Select the channel addressed by idx and form its weighted contribution.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    cur_sample = '0;
    cur_gain   = '0;
    cur_ena    = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_sample = samples_q[i*N +: N];
        cur_gain   = gains_q[i*G +: G];
        cur_ena    = ena_q[i];
      end
    end
    // Product of N-bit and G-bit operands fits in ACC_W bits exactly.
    term = cur_ena ? (ACC_W'(cur_sample) * ACC_W'(cur_gain)) : '0;
  end

  // Truncating shift followed by saturation to the output range.
  always_comb begin
    shifted = CMP_W'(acc >> SHIFT);
    sat     = (shifted > OUT_MAX);
    mix_out = sat ? OUT_W'(OUT_MAX) : OUT_W'(shifted);
  end

  // Input capture registers.
  // NOTE: pure datapath storage is left out of reset: it is always written
  // before use (on the tick that starts a mix), so a reset would only add
  // fan-out on rst without changing behaviour.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      samples_q <= samples;
      gains_q   <= gains;
      ena_q     <= channel_ena;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state       <= IDLE;
      acc         <= '0;
      idx         <= '0;
      audio       <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
      clip        <= 1'b0;
      clip_count  <= '0;
`endif
    end else begin
      audio_valid <= 1'b0;
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
      clip        <= 1'b0;
`endif
      // A tick outside IDLE (including the DONE cycle) is dropped and
      // flagged; a new event wins over a simultaneous clear.
      overrun <= (overrun & ~overrun_clr) | (sample_tick & (state != IDLE));

      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end

        ACCUM: begin
          acc <= acc + term;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          audio       <= mix_out;
          audio_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
          clip <= sat;
          if (sat && clip_count != 8'hFF) begin
            clip_count <= clip_count + 8'd1;
          end
`endif
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weighted_mixer.sv
// -----------------------------------------------------------------------------
// tb_weighted_mixer
//
// Self-checking bench for weighted_mixer (NUM=4, N=10, G=4, SHIFT=3,
// OUT_W=12). Expected mixes come from a plain arithmetic reference model:
// sum of enabled sample*gain, shifted, clamped to the output range.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_weighted_mixer;

  localparam int NUM   = 4;
  localparam int N     = 10;
  localparam int G     = 4;
  localparam int SHIFT = 3;
  localparam int OUT_W = 12;
  localparam longint OUT_MAX = (64'd1 << OUT_W) - 1;

  logic               clk;
  logic               rst;
  logic [NUM*N-1:0]   samples;
  logic [NUM*G-1:0]   gains;
  logic [NUM-1:0]     channel_ena;
  logic               sample_tick;
  logic               overrun_clr;
  logic [OUT_W-1:0]   audio;
  logic               audio_valid;
  logic               busy;
  logic               overrun;
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
  logic               clip;
  logic [7:0]         clip_count;
  int                 exp_clip_count = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  weighted_mixer #(
    .NUM   (NUM),
    .N     (N),
    .G     (G),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .samples     (samples),
    .gains       (gains),
    .channel_ena (channel_ena),
    .sample_tick (sample_tick),
    .overrun_clr (overrun_clr),
    .audio       (audio),
    .audio_valid (audio_valid),
    .busy        (busy),
    .overrun     (overrun)
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
    ,
    .clip        (clip),
    .clip_count  (clip_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: weighted sum of enabled channels, truncating shift, clamp.
  function automatic longint model_mix(input logic [NUM*N-1:0] s,
                                       input logic [NUM*G-1:0] g,
                                       input logic [NUM-1:0]   e,
                                       output bit              clipped);
    longint sum = 0;
    for (int i = 0; i < NUM; i++) begin
      if (e[i]) sum += longint'(s[i*N +: N]) * longint'(g[i*G +: G]);
    end
    sum = sum / (64'd1 << SHIFT);
    clipped = (sum > OUT_MAX);
    return clipped ? OUT_MAX : sum;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count audio_valid pulses over n cycles.
  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (audio_valid) pulses++;
    end
  endtask

  // One full mix. after_tick: 0 keep inputs, 1 zero samples, 2 randomize
  // all inputs right after the tick is taken.
  task automatic do_mix(input string tag,
                        input logic [NUM*N-1:0] s,
                        input logic [NUM*G-1:0] g,
                        input logic [NUM-1:0]   e,
                        input int               after_tick);
    longint exp_audio;
    bit     exp_clip;
    int     cycles;
    samples     = s;
    gains       = g;
    channel_ena = e;
    sample_tick = 1'b1;
    exp_audio   = model_mix(s, g, e, exp_clip);
    step();                                   // edge T: tick taken
    sample_tick = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    if (after_tick == 1) samples = '0;
    if (after_tick == 2) begin
      for (int i = 0; i < NUM; i++) samples[i*N +: N] = N'($urandom);
      gains       = NUM*G'($urandom);
      channel_ena = NUM'($urandom);
    end
    cycles = 0;
    while (!audio_valid && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_latency"}, cycles, NUM + 1);
    check({tag, "_audio"}, audio, exp_audio);
    check({tag, "_busy_end"}, busy, 0);
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
    if (exp_clip && exp_clip_count < 255) exp_clip_count++;
    check({tag, "_clip"}, clip, exp_clip);
    check({tag, "_clip_count"}, clip_count, exp_clip_count);
`endif
    step();
    check({tag, "_valid_single"}, audio_valid, 0);
    check({tag, "_audio_hold"}, audio, exp_audio);
  endtask

  localparam logic [NUM*N-1:0] S_512  = {NUM{10'd512}};
  localparam logic [NUM*N-1:0] S_FULL = {NUM{10'd1023}};
  localparam logic [NUM*G-1:0] G_8    = {NUM{4'd8}};
  localparam logic [NUM*G-1:0] G_15   = {NUM{4'd15}};

  initial begin
    int pulses;
    logic [NUM*N-1:0] rs;
    logic [NUM*G-1:0] rg;

    rst         = 1'b0;
    samples     = '0;
    gains       = '0;
    channel_ena = '0;
    sample_tick = 1'b0;
    overrun_clr = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_audio", audio, 0);
    check("rst_valid", audio_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
    check("rst_clip_count", clip_count, 0);
`endif
    rst = 1'b1;
    step();

    // Unity gain mix, saturating mix, single enabled channel.
    do_mix("unity", S_512, G_8, 4'b1111, 0);
    do_mix("saturate", S_FULL, G_15, 4'b1111, 0);
    do_mix("ena0001", {10'd1023, 10'd1023, 10'd1023, 10'd100},
           {4'd15, 4'd15, 4'd15, 4'd8}, 4'b0001, 0);
    // Inputs zeroed after the tick must not affect the mix.
    do_mix("latched", S_512, G_8, 4'b1111, 1);

    // Second tick two cycles after the first: dropped, overrun set.
    samples = S_512; gains = G_8; channel_ena = 4'b1111;
    sample_tick = 1'b1;
    step();                                   // T
    sample_tick = 1'b0;
    step();                                   // T+1
    sample_tick = 1'b1;
    step();                                   // T+2
    sample_tick = 1'b0;
    check("ovr_set", overrun, 1);
    watch(12, pulses);
    check("ovr_one_valid", pulses, 1);
    check("ovr_audio", audio, 2048);
    check("ovr_sticky", overrun, 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // New overrun event together with clear keeps the flag set.
    sample_tick = 1'b1;
    step();                                   // T
    step();                                   // T+1: overrun event
    overrun_clr = 1'b1;
    step();                                   // T+2: event and clear
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
    check("ovr_clr_vs_set", overrun, 1);
    watch(8, pulses);
    check("ovr2_one_valid", pulses, 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr2_clr", overrun, 0);

    // Tick landing on the DONE cycle counts as busy.
    sample_tick = 1'b1;
    step();                                   // T
    sample_tick = 1'b0;
    repeat (NUM) step();                      // T+1 .. T+NUM
    sample_tick = 1'b1;
    step();                                   // T+NUM+1: DONE -> IDLE
    sample_tick = 1'b0;
    check("done_tick_valid", audio_valid, 1);
    check("done_tick_overrun", overrun, 1);
    check("done_tick_not_busy", busy, 0);
    watch(10, pulses);
    check("done_tick_no_restart", pulses, 0);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;

    // Reset two cycles into a mix aborts it.
    samples = S_FULL; gains = G_15;
    sample_tick = 1'b1;
    step();                                   // T
    sample_tick = 1'b0;
    step();                                   // T+1
    rst = 1'b0;
    step();                                   // T+2: reset taken
    rst = 1'b1;
    check("abort_audio", audio, 0);
    check("abort_busy", busy, 0);
`ifdef WEIGHTED_MIXER_CLIP_DETECT_EN
    exp_clip_count = 0;
    check("abort_clip_count", clip_count, 0);
`endif
    watch(10, pulses);
    check("abort_no_valid", pulses, 0);
    do_mix("after_abort", S_512, G_8, 4'b1111, 0);

    // Randomized mixes, inputs scrambled while each mix runs.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NUM; i++) begin
        rs[i*N +: N] = (t % 3 == 0) ? N'(1023 - $urandom_range(0, 15)) : N'($urandom);
        rg[i*G +: G] = G'($urandom);
      end
      do_mix("rand", rs, rg, NUM'($urandom), 2);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
